// File: rtl/board_manager_if.sv
// rtl/board_manager_if.sv - drop request/response handshake bundle for board_manager
interface board_manager_if;
  logic       drop_valid;
  logic [2:0] drop_col;
  logic [1:0] drop_player;
  logic       drop_ready;
  logic       drop_done;
  logic       drop_ok;
  logic [2:0] drop_row;

  modport master (
    output drop_valid, drop_col, drop_player,
    input  drop_ready, drop_done, drop_ok, drop_row
  );

  modport slave (
    input  drop_valid, drop_col, drop_player,
    output drop_ready, drop_done, drop_ok, drop_row
  );
endinterface

// File: rtl/board_manager.sv
// rtl/board_manager.sv - 6x7 drop-column board store with bottom-up scan and debug read port
module board_manager (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  board_manager_if.slave     drop,
  input  logic               read_board,
  input  logic [2:0]         d_r_row,
  input  logic [2:0]         d_r_col,
  output logic [1:0]         piece_data,
  output logic [5:0]         piece_count,
  output logic               board_full
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_n;
  logic [1:0] cells [6][7];   // [row][col], row 0 is the bottom
  logic [2:0] scan_row;
  logic [2:0] lat_col;
  logic [1:0] lat_player;
  logic       ok_q;
  logic [2:0] row_q;
  logic [5:0] count_q;

  logic       accept;
  logic       req_valid;
  logic [1:0] cur_cell;
  logic       do_write;
  logic       do_fail;
  logic       scan_inc;

  assign drop.drop_ready = (state == IDLE) && !clear;
  assign drop.drop_done  = (state == DONE);
  assign drop.drop_ok    = ok_q;
  assign drop.drop_row   = row_q;
  assign piece_count     = count_q;
  assign board_full      = (count_q == 6'd42);

  assign accept    = drop.drop_valid && drop.drop_ready;
  // Bad column or non-player code is rejected without ever touching storage.
  assign req_valid = (lat_col <= 3'd6) && (lat_player == 2'b01 || lat_player == 2'b10);
  assign cur_cell  = (req_valid && scan_row <= 3'd5) ? cells[scan_row][lat_col] : 2'b00;

  // Debug read sees storage before any write landing on the same edge.
  assign piece_data = (read_board && d_r_row <= 3'd5 && d_r_col <= 3'd6)
                      ? cells[d_r_row][d_r_col] : 2'b00;

  // Next-state and scan decisions; clear overrides everything and kills any write.
  always_comb begin
    state_n  = state;
    do_write = 1'b0;
    do_fail  = 1'b0;
    scan_inc = 1'b0;
    case (state)
      IDLE: if (accept) state_n = SCAN;
      SCAN: begin
        if (!req_valid) begin
          do_fail = 1'b1;
          state_n = DONE;
        end else if (cur_cell == 2'b00) begin
          do_write = 1'b1;
          state_n  = DONE;
        end else if (scan_row == 3'd5) begin
          do_fail = 1'b1;
          state_n = DONE;
        end else begin
          scan_inc = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear) begin
      state_n  = IDLE;
      do_write = 1'b0;
      do_fail  = 1'b0;
      scan_inc = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Request latch, scan row and the held drop result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_row   <= 3'd0;
      lat_col    <= 3'd0;
      lat_player <= 2'b00;
      ok_q       <= 1'b0;
      row_q      <= 3'd0;
    end else if (clear) begin
      scan_row <= 3'd0;
    end else begin
      if (accept) begin
        lat_col    <= drop.drop_col;
        lat_player <= drop.drop_player;
        scan_row   <= 3'd0;
      end
      if (scan_inc) scan_row <= scan_row + 3'd1;
      if (do_write) begin
        ok_q  <= 1'b1;
        row_q <= scan_row;
      end
      if (do_fail) ok_q <= 1'b0;
    end
  end

  // Board storage and piece counter; a write only ever lands on an empty cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++)
          cells[r][c] <= 2'b00;
      count_q <= 6'd0;
    end else if (clear) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++)
          cells[r][c] <= 2'b00;
      count_q <= 6'd0;
    end else if (do_write) begin
      cells[scan_row][lat_col] <= lat_player;
      if (count_q != 6'd42) count_q <= count_q + 6'd1;
    end
  end

endmodule

// File: tb/tb_board_manager.sv
// tb/tb_board_manager.sv - scoreboard bench for board_manager
module tb_board_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       read_board = 1'b0;
  logic [2:0] d_r_row = 3'd0;
  logic [2:0] d_r_col = 3'd0;
  logic [1:0] piece_data;
  logic [5:0] piece_count;
  logic       board_full;

  board_manager_if bif ();

  board_manager dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .drop        (bif.slave),
    .read_board  (read_board),
    .d_r_row     (d_r_row),
    .d_r_col     (d_r_col),
    .piece_data  (piece_data),
    .piece_count (piece_count),
    .board_full  (board_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ok;
    logic [2:0] row;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every drop_done pops one expected response.
  always @(negedge clk) begin
    if (rst_n && bif.drop_done) begin
      if (sb.size() == 0) begin
        check("unexpected_drop_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("drop_ok", int'(bif.drop_ok), int'(e.ok));
        if (e.ok) check("drop_row", int'(bif.drop_row), int'(e.row));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one drop; done_edge is the edge (acceptance = 1) after which drop_done is due.
  task automatic issue_drop(input logic [2:0] col, input logic [1:0] pl,
                            input logic ok, input logic [2:0] row,
                            input int done_edge, input bit expect_done);
    int a;
    exp_t e;
    @(negedge clk);
    check("ready_before_drop", int'(bif.drop_ready), 1);
    bif.drop_valid  = 1'b1;
    bif.drop_col    = col;
    bif.drop_player = pl;
    @(posedge clk);
    #1;
    a = cyc;
    bif.drop_valid = 1'b0;
    if (expect_done) begin
      e.ok  = ok;
      e.row = row;
      e.cyc = a + done_edge - 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      check("drop_done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_drop(input logic [2:0] col, input logic [1:0] pl,
                         input logic ok, input logic [2:0] row, input int done_edge);
    issue_drop(col, pl, ok, row, done_edge, 1'b1);
    wait_done();
  endtask

  task automatic read_cell(input logic [2:0] r, input logic [2:0] c, output logic [1:0] v);
    read_board = 1'b1;
    d_r_row    = r;
    d_r_col    = c;
    #1;
    v = piece_data;
  endtask

  logic [1:0] v;
  logic [1:0] pl;

  initial begin
    bif.drop_valid  = 1'b0;
    bif.drop_col    = 3'd0;
    bif.drop_player = 2'b00;

    // Reset state while rst_n is low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_drop_done", int'(bif.drop_done), 0);
    check("rst_drop_ok", int'(bif.drop_ok), 0);
    check("rst_drop_row", int'(bif.drop_row), 0);
    check("rst_piece_count", int'(piece_count), 0);
    check("rst_board_full", int'(board_full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", int'(bif.drop_ready), 1);
    read_cell(3'd0, 3'd0, v); check("post_rst_read00", int'(v), 0);
    read_cell(3'd5, 3'd6, v); check("post_rst_read56", int'(v), 0);

    // First drop, col 3 player 1, with the debug port watching the target cell.
    read_cell(3'd0, 3'd3, v);
    issue_drop(3'd3, 2'b01, 1'b1, 3'd0, 2, 1'b1);
    check("write_edge_pre_value", int'(piece_data), 0);
    @(posedge clk);
    #1;
    check("write_edge_post_value", int'(piece_data), 1);
    wait_done();
    read_cell(3'd0, 3'd3, v); check("read_0_3", int'(v), 1);
    check("count_after_first", int'(piece_count), 1);

    // Stack column 0 with alternating players; k pieces -> done after edge k+2.
    for (int k = 0; k < 6; k++) begin
      pl = (k % 2 == 0) ? 2'b01 : 2'b10;
      do_drop(3'd0, pl, 1'b1, 3'(k), k + 2);
    end
    do_drop(3'd0, 2'b01, 1'b0, 3'd0, 7);
    check("count_after_col0", int'(piece_count), 7);
    read_cell(3'd5, 3'd0, v); check("read_5_0", int'(v), 2);
    read_cell(3'd4, 3'd0, v); check("read_4_0", int'(v), 1);

    // Invalid requests.
    do_drop(3'd7, 2'b01, 1'b0, 3'd0, 2);
    do_drop(3'd1, 2'b11, 1'b0, 3'd0, 2);
    do_drop(3'd1, 2'b00, 1'b0, 3'd0, 2);
    check("count_after_invalid", int'(piece_count), 7);
    read_cell(3'd0, 3'd1, v); check("invalid_no_write", int'(v), 0);

    // Debug addressing corners.
    read_cell(3'd6, 3'd0, v); check("read_row6", int'(v), 0);
    read_cell(3'd0, 3'd7, v); check("read_col7", int'(v), 0);
    read_board = 1'b0; d_r_row = 3'd0; d_r_col = 3'd0; #1;
    check("read_disabled", int'(piece_data), 0);

    // Clear aborts a scan over a 4-high column.
    for (int k = 0; k < 4; k++) do_drop(3'd1, 2'b10, 1'b1, 3'(k), k + 2);
    issue_drop(3'd1, 2'b01, 1'b0, 3'd0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    check("clear_abort_ready", int'(bif.drop_ready), 1);
    check("clear_abort_count", int'(piece_count), 0);
    read_cell(3'd4, 3'd1, v); check("clear_abort_no_write", int'(v), 0);
    read_cell(3'd0, 3'd1, v); check("clear_wiped", int'(v), 0);
    repeat (8) @(negedge clk);

    // Reset pulse aborts a scan.
    for (int k = 0; k < 3; k++) do_drop(3'd2, 2'b01, 1'b1, 3'(k), k + 2);
    issue_drop(3'd2, 2'b10, 1'b0, 3'd0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_abort_done_low", int'(bif.drop_done), 0);
    check("rst_abort_count_now", int'(piece_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_abort_ready", int'(bif.drop_ready), 1);
    read_cell(3'd3, 3'd2, v); check("rst_abort_no_write", int'(v), 0);
    repeat (8) @(negedge clk);
    check("rst_abort_count", int'(piece_count), 0);

    // Fill the whole board.
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        pl = ((r + c) % 2 == 0) ? 2'b01 : 2'b10;
        do_drop(3'(c), pl, 1'b1, 3'(r), r + 2);
      end
    check("full_count", int'(piece_count), 42);
    check("full_flag", int'(board_full), 1);
    read_cell(3'd5, 3'd6, v); check("full_read_5_6", int'(v), 2);
    do_drop(3'd4, 2'b01, 1'b0, 3'd0, 7);
    check("full_count_hold", int'(piece_count), 42);

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clear_full_flag", int'(board_full), 0);
    check("clear_count", int'(piece_count), 0);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        read_cell(3'(r), 3'(c), v);
        check("clear_read", int'(v), 0);
      end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
